hw_checksum_inserter: RTL and testbench
=======================================

# hw_checksum_inserter

Store-and-forward stage directly downstream of the TCP/UDP pseudo-header checksum generator in the Ethernet packet engine. It buffers one L4 segment byte-by-byte while the generator computes, waits for the generator's sticky done flag, then replays the segment with the 16-bit checksum patched big-endian at a programmable byte offset. Output uses a valid/ready byte stream towards the MAC TX path.

## Interface
- ADDR_W, 11, buffer address width; depth = 2^ADDR_W bytes (2048)
- pe_clk  in  1  packet-engine clock
- pe_rstn  in  1  reset pe_rstn, asynchronous, active-low; clock pe_clk
- pe_logic_clr  in  1  synchronous soft clear, same effect as reset
- in_valid  in  1  input byte valid; no backpressure, accepted whenever state is FILL or IDLE
- in_data  in  8  input byte, same stream the checksum generator sees
- in_last  in  1  marks final byte of segment, qualified by in_valid
- csum_offset  in  ADDR_W  byte index of checksum MSB within segment (UDP 6, TCP 16); sampled on first byte
- csum_in  in  16  checksum from generator (hw_checksum_out[15:0])
- csum_done  in  1  generator done, level, sticky until pe_logic_clr
- out_valid  out  1  output byte valid
- out_data  out  8  output byte
- out_last  out  1  final output byte
- out_ready  in  1  downstream accept
- busy  out  1  high in any state except IDLE
- drop  out  1  one-cycle pulse when a segment is discarded

## Operation
- States: IDLE, FILL, WAIT_CSUM, DRAIN.
- IDLE: in_valid writes byte to addr 0, latches csum_offset, wr_cnt=1; -> FILL, or -> WAIT_CSUM if in_last.
- FILL: each in_valid writes at wr_cnt, wr_cnt++; in_last -> WAIT_CSUM with len=wr_cnt+1.
- Overflow: in_valid in FILL with wr_cnt==2^ADDR_W: byte discarded, ovf flag set, remaining bytes to in_last ignored; at in_last pulse drop, -> IDLE.
- WAIT_CSUM: on csum_done high, latch csum_in into csum_q; -> DRAIN. csum_done already high on entry is accepted the next cycle.
- DRAIN: read pointer rd_cnt from 0 to len-1; byte at csum_offset replaced by csum_q[15:8], at csum_offset+1 by csum_q[7:0]; out_last at rd_cnt==len-1; after that byte handshakes -> IDLE.
- Offset out of range (csum_offset+1 >= len): segment drained unmodified, no drop.
- in_valid outside IDLE/FILL is ignored (bytes lost); upstream guarantees gap.
- pe_logic_clr or reset in any state: -> IDLE, counters 0, csum_q 0, buffered data abandoned, no drop pulse.
- Width rules: wr_cnt/rd_cnt are ADDR_W+1 bits; len ranges 1..2^ADDR_W.

## Timing
- Reset values: out_valid 0, out_data 0x00, out_last 0, busy 0, drop 0.
- Buffer: single-port-write/single-port-read RAM, registered read, 1-cycle latency.
- First out_valid 2 cycles after csum_done rises (1 cycle latch, 1 cycle RAM read).
- Output register holds out_data/out_last stable while out_valid && !out_ready; one prefetch register keeps full throughput of 1 byte/cycle with out_ready tied high.
- drop asserted the cycle after the offending in_last.
- busy rises the cycle after first accepted byte, falls the cycle after last output handshake.

## Configuration
- HW_CSUM_UDP_ZERO_SUBST_EN defined: csum_in==0x0000 is latched as 0xFFFF (RFC 768 transmitted-zero rule).
- Not defined: csum_in latched verbatim.

## Structure
- Shared eth_pe package: state encoding constants (IDLE/FILL/WAIT_CSUM/DRAIN), default offsets CSUM_OFS_UDP=6, CSUM_OFS_TCP=16.
- One sub-module: hw_checksum_buf_ram (ADDR_W-parameterised 8-bit RAM, registered read); FSM, counters and patch mux stay in the top.

## Test plan
- 8-byte UDP segment 00..07, offset 6, csum_in 0xA55A, out_ready=1 -> output 00 01 02 03 04 05 A5 5A, out_last on byte 8, 1 byte/cycle.
- 20-byte TCP segment, offset 16, random out_ready toggling -> bytes 16/17 patched, out_data stable during stalls, no duplicates/losses.
- csum_in 0x0000 -> patched 0xFFFF with HW_CSUM_UDP_ZERO_SUBST_EN, 0x0000 without.
- 2049-byte segment, ADDR_W=11 -> drop one pulse after in_last, out_valid never asserted, next 4-byte segment passes correctly.
- Segment of 4 bytes, offset 6 -> drained unmodified, no drop.
- pe_logic_clr mid-DRAIN after 3 bytes -> out_valid 0 next cycle, busy 0, next segment starts at addr 0 correctly.

Source files
------------

// File: rtl/hw_checksum_inserter_pkg.sv
// Shared packet-engine constants for the checksum inserter: FSM encoding, default L4 offsets, checksum fixup.
// HW_CSUM_UDP_ZERO_SUBST_EN: when defined, a computed 0x0000 checksum is transmitted as 0xFFFF.
package hw_checksum_inserter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_WAIT_CSUM = 2'd2,
        ST_DRAIN     = 2'd3
    } pe_state_e;

    localparam int unsigned CSUM_OFS_UDP = 6;
    localparam int unsigned CSUM_OFS_TCP = 16;

    function automatic logic [15:0] csum_fixup(input logic [15:0] c);
`ifdef HW_CSUM_UDP_ZERO_SUBST_EN
        // UDP reserves 0x0000 for "no checksum"; ones-complement zero goes out as all-ones.
        return (c == 16'h0000) ? 16'hFFFF : c;
`else
        return c;
`endif
    endfunction

endpackage

// File: rtl/hw_checksum_inserter_if.sv
// Byte streams around the checksum inserter: unthrottled input, valid/ready output.
// master drives the input stream and out_ready; slave is the inserter's view.
interface hw_checksum_inserter_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    modport master (output in_valid, in_data, in_last, out_ready,
                    input  out_valid, out_data, out_last);
    modport slave  (input  in_valid, in_data, in_last, out_ready,
                    output out_valid, out_data, out_last);
endinterface

// File: rtl/hw_checksum_buf_ram.sv
// Segment buffer: 2^ADDR_W x 8 simple dual-port RAM, one write port, one read port.
// Latency: registered read, data valid one cycle after rd_en; rd_data holds while rd_en is low.
// Backpressure: none; the caller stalls by withholding rd_en.
module hw_checksum_buf_ram #(
    parameter int ADDR_W = 11
) (
    input  logic              pe_clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);
    logic [7:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge pe_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data      <= mem[rd_addr];
    end
endmodule

// File: rtl/hw_checksum_inserter.sv
// Store-and-forward L4 segment buffer that patches the generator's checksum big-endian at csum_offset.
// Latency: first out byte 2 cycles after csum_done; then 1 byte/cycle. Optional HW_CSUM_UDP_ZERO_SUBST_EN.
// Backpressure: input has none (overflow drops the segment); output stalls on out_ready with stable data.
module hw_checksum_inserter
    import hw_checksum_inserter_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic                  pe_clk,
    input  logic                  pe_rstn,
    input  logic                  pe_logic_clr,
    hw_checksum_inserter_if.slave seg,
    input  logic [ADDR_W-1:0]     csum_offset,
    input  logic [15:0]           csum_in,
    input  logic                  csum_done,
    output logic                  busy,
    output logic                  drop
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    pe_state_e         state, state_nxt;
    logic [CW-1:0]     wr_cnt, rd_cnt, len, d_idx;
    logic [ADDR_W-1:0] ofs_q;
    logic              ovf;
    logic [15:0]       csum_q;
    logic              d_vld;
    logic              drop_q;

    logic              idle_take, fill_take, fill_full, ovf_end;
    logic              wr_en, rd_en, csum_take;
    logic [ADDR_W-1:0] wr_addr;
    logic              out_hs, out_load, d_free, drain_end;
    logic [7:0]        ram_dout, patch_dat;
    logic [CW-1:0]     ofs_ext;
    logic              ofs_ok, d_last;

    assign idle_take = (state == ST_IDLE) && seg.in_valid;
    assign fill_take = (state == ST_FILL) && seg.in_valid;
    assign fill_full = ovf || (wr_cnt == DEPTH);
    assign ovf_end   = fill_take && seg.in_last && fill_full;
    assign wr_en     = idle_take || (fill_take && !fill_full);
    assign wr_addr   = idle_take ? '0 : wr_cnt[ADDR_W-1:0];
    assign csum_take = (state == ST_WAIT_CSUM) && csum_done;

    // The RAM output register doubles as the prefetch stage: it only advances when
    // the output register is empty or being consumed, so no extra skid buffer is needed.
    assign out_hs    = seg.out_valid && seg.out_ready;
    assign out_load  = !seg.out_valid || seg.out_ready;
    assign d_free    = !d_vld || out_load;
    assign rd_en     = (csum_take || (state == ST_DRAIN)) && (rd_cnt < len) && d_free;
    assign drain_end = (state == ST_DRAIN) && out_hs && seg.out_last;

    assign ofs_ext   = {1'b0, ofs_q};
    assign ofs_ok    = (ofs_ext + ONE) < len;
    assign d_last    = (d_idx == len - ONE);
    always_comb begin
        patch_dat = ram_dout;
        if (ofs_ok && d_idx == ofs_ext)             patch_dat = csum_q[15:8];
        else if (ofs_ok && d_idx == ofs_ext + ONE)  patch_dat = csum_q[7:0];
    end

    hw_checksum_buf_ram #(.ADDR_W(ADDR_W)) u_buf (
        .pe_clk  (pe_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (seg.in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_cnt[ADDR_W-1:0]),
        .rd_data (ram_dout)
    );

    always_ff @(posedge pe_clk or negedge pe_rstn) begin
        if (!pe_rstn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (seg.in_valid) state_nxt = seg.in_last ? ST_WAIT_CSUM : ST_FILL;
            ST_FILL:      if (seg.in_valid && seg.in_last) state_nxt = fill_full ? ST_IDLE : ST_WAIT_CSUM;
            ST_WAIT_CSUM: if (csum_done) state_nxt = ST_DRAIN;
            ST_DRAIN:     if (drain_end) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
        if (pe_logic_clr) state_nxt = ST_IDLE;
    end

    always_comb begin
        busy = (state != ST_IDLE);
        drop = drop_q;
    end

    always_ff @(posedge pe_clk or negedge pe_rstn) begin
        if (!pe_rstn) begin
            wr_cnt <= '0;  rd_cnt <= '0;  len <= '0;  d_idx <= '0;
            ofs_q  <= '0;  ovf    <= 1'b0; csum_q <= '0; d_vld <= 1'b0;
            drop_q <= 1'b0;
            seg.out_valid <= 1'b0; seg.out_data <= '0; seg.out_last <= 1'b0;
        end else if (pe_logic_clr) begin
            wr_cnt <= '0;  rd_cnt <= '0;  len <= '0;  d_idx <= '0;
            ofs_q  <= '0;  ovf    <= 1'b0; csum_q <= '0; d_vld <= 1'b0;
            drop_q <= 1'b0;
            seg.out_valid <= 1'b0; seg.out_data <= '0; seg.out_last <= 1'b0;
        end else begin
            drop_q <= ovf_end;
            if (idle_take) begin
                ofs_q  <= csum_offset;
                wr_cnt <= ONE;
                rd_cnt <= '0;
                ovf    <= 1'b0;
                if (seg.in_last) len <= ONE;
            end
            if (fill_take) begin
                if (fill_full) ovf <= 1'b1;
                else           wr_cnt <= wr_cnt + ONE;
                if (seg.in_last && !fill_full) len <= wr_cnt + ONE;
            end
            if (csum_take) csum_q <= csum_fixup(csum_in);
            if (rd_en) begin
                rd_cnt <= rd_cnt + ONE;
                d_idx  <= rd_cnt;
                d_vld  <= 1'b1;
            end else if (out_load) begin
                d_vld  <= 1'b0;
            end
            if (out_load) begin
                seg.out_valid <= d_vld;
                seg.out_last  <= d_vld && d_last;
                if (d_vld) seg.out_data <= patch_dat;
            end
        end
    end
endmodule

// File: tb/tb_hw_checksum_inserter.sv
// Directed bench for hw_checksum_inserter: UDP/TCP patching, stalls, zero checksum, overflow, out-of-range offset, soft clear.
module tb_hw_checksum_inserter;
    import hw_checksum_inserter_pkg::*;

    localparam int ADDR_W = 11;
`ifdef HW_CSUM_UDP_ZERO_SUBST_EN
    localparam logic [15:0] ZERO_EXP = 16'hFFFF;
`else
    localparam logic [15:0] ZERO_EXP = 16'h0000;
`endif

    logic              pe_clk = 1'b0;
    logic              pe_rstn = 1'b0;
    logic              pe_logic_clr = 1'b0;
    logic [ADDR_W-1:0] csum_offset = '0;
    logic [15:0]       csum_in = '0;
    logic              csum_done = 1'b0;
    logic              busy, drop;

    hw_checksum_inserter_if ifc();

    hw_checksum_inserter #(.ADDR_W(ADDR_W)) dut (
        .pe_clk       (pe_clk),
        .pe_rstn      (pe_rstn),
        .pe_logic_clr (pe_logic_clr),
        .seg          (ifc),
        .csum_offset  (csum_offset),
        .csum_in      (csum_in),
        .csum_done    (csum_done),
        .busy         (busy),
        .drop         (drop)
    );

    always #5 pe_clk = ~pe_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge pe_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected output byte i of an n-byte segment whose payload is base+i.
    function automatic logic [7:0] exp_byte(input int i, input int n, input int base,
                                            input int ofs, input logic [15:0] cs);
        logic [7:0] b;
        b = 8'(base + i);
        if (ofs + 1 < n && i == ofs)          b = cs[15:8];
        else if (ofs + 1 < n && i == ofs + 1) b = cs[7:0];
        return b;
    endfunction

    task automatic send_seg(input string tag, input int n, input int base, input int ofs,
                            input logic exp_drop);
        for (int i = 0; i < n; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = 8'(base + i);
            ifc.in_last  = (i == n - 1);
            csum_offset  = ADDR_W'(ofs);
            tick();
            if (i == 0) check({tag, "_busy_rise"}, busy, 1'b1);
        end
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        check({tag, "_drop"}, drop, exp_drop);
    endtask

    task automatic drain(input string tag, input int n, input int base, input int ofs,
                         input logic [15:0] cs_in, input logic [15:0] cs_exp, input bit stall);
        int got = 0;
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic [7:0] prev_dat = '0;
        csum_in   = cs_in;
        csum_done = 1'b1;
        while (got < n && cyc < 400) begin
            ifc.out_ready = stall ? ((cyc % 3) != 1) : 1'b1;
            if (prev_stall) begin
                check($sformatf("%s_hold_vld_c%0d", tag, cyc), ifc.out_valid, 1'b1);
                check($sformatf("%s_hold_dat_c%0d", tag, cyc), ifc.out_data, prev_dat);
            end
            if (ifc.out_valid && ifc.out_ready) begin
                check($sformatf("%s_dat%0d", tag, got), ifc.out_data, exp_byte(got, n, base, ofs, cs_exp));
                check($sformatf("%s_last%0d", tag, got), ifc.out_last, (got == n - 1));
                got++;
            end
            prev_stall = ifc.out_valid && !ifc.out_ready;
            prev_dat   = ifc.out_data;
            tick();
            cyc++;
        end
        ifc.out_ready = 1'b1;
        check({tag, "_count"}, got, n);
        check({tag, "_end_vld"}, ifc.out_valid, 1'b0);
        check({tag, "_end_busy"}, busy, 1'b0);
        csum_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic seen_vld;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.in_last   = 1'b0;
        ifc.out_ready = 1'b1;

        repeat (3) tick();
        check("rst_out_valid", ifc.out_valid, 1'b0);
        check("rst_out_data",  ifc.out_data, 8'h00);
        check("rst_out_last",  ifc.out_last, 1'b0);
        check("rst_busy",      busy, 1'b0);
        check("rst_drop",      drop, 1'b0);
        pe_rstn = 1'b1;
        tick();

        // UDP 8 bytes: latency and full throughput with ready held high
        send_seg("udp", 8, 8'h00, CSUM_OFS_UDP, 1'b0);
        csum_in   = 16'hA55A;
        csum_done = 1'b1;
        tick();
        check("udp_lat1", ifc.out_valid, 1'b0);
        tick();
        check("udp_lat2", ifc.out_valid, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("udp_vld%0d", i), ifc.out_valid, 1'b1);
            check($sformatf("udp_dat%0d", i), ifc.out_data, exp_byte(i, 8, 8'h00, 6, 16'hA55A));
            check($sformatf("udp_last%0d", i), ifc.out_last, (i == 7));
            tick();
        end
        check("udp_end_vld", ifc.out_valid, 1'b0);
        check("udp_end_busy", busy, 1'b0);
        csum_done = 1'b0;

        // TCP 20 bytes under output stalls
        send_seg("tcp", 20, 8'h80, CSUM_OFS_TCP, 1'b0);
        drain("tcp", 20, 8'h80, CSUM_OFS_TCP, 16'hC3E1, 16'hC3E1, 1'b1);

        // Zero checksum
        send_seg("zero", 8, 8'h20, CSUM_OFS_UDP, 1'b0);
        drain("zero", 8, 8'h20, CSUM_OFS_UDP, 16'h0000, ZERO_EXP, 1'b0);

        // Offset range boundaries on a 4-byte segment
        send_seg("oob6", 4, 8'h30, 6, 1'b0);
        drain("oob6", 4, 8'h30, 6, 16'h5555, 16'h5555, 1'b0);
        send_seg("oob3", 4, 8'h38, 3, 1'b0);
        drain("oob3", 4, 8'h38, 3, 16'h6666, 16'h6666, 1'b0);
        send_seg("in2", 4, 8'h3C, 2, 1'b0);
        drain("in2", 4, 8'h3C, 2, 16'h7788, 16'h7788, 1'b0);

        // Overflow: 2049 bytes into a 2048-byte buffer
        send_seg("ovf", 2049, 8'h00, CSUM_OFS_UDP, 1'b1);
        check("ovf_busy", busy, 1'b0);
        tick();
        check("ovf_drop_clr", drop, 1'b0);
        csum_done = 1'b1;
        seen_vld  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen_vld = seen_vld | ifc.out_valid;
            tick();
        end
        check("ovf_no_out", seen_vld, 1'b0);
        csum_done = 1'b0;
        tick();
        send_seg("post_ovf", 4, 8'hC0, 0, 1'b0);
        drain("post_ovf", 4, 8'hC0, 0, 16'hBEEF, 16'hBEEF, 1'b0);

        // Soft clear after three drained bytes
        send_seg("clr", 8, 8'h40, CSUM_OFS_UDP, 1'b0);
        csum_in   = 16'h1111;
        csum_done = 1'b1;
        w = 0;
        while (!ifc.out_valid && w < 10) begin
            tick();
            w++;
        end
        check("clr_first_vld", ifc.out_valid, 1'b1);
        repeat (3) tick();
        pe_logic_clr = 1'b1;
        csum_done    = 1'b0;
        tick();
        check("clr_out_valid", ifc.out_valid, 1'b0);
        check("clr_busy", busy, 1'b0);
        pe_logic_clr = 1'b0;
        tick();
        send_seg("post_clr", 4, 8'hB0, 0, 1'b0);
        drain("post_clr", 4, 8'hB0, 0, 16'h1234, 16'h1234, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
